// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Build option: DMEM_BYTE_EN enables per-byte store enables.
package dmem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } req_t;

  // Misaligned or beyond the last implemented word.
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                    input int unsigned       depth_words);
    return (addr[1:0] != 2'b00) ||
           (addr[ADDR_W-1:2] >= (ADDR_W-2)'(depth_words));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: single port, synchronous byte-lane write, combinational read.
// Contents are deliberately not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 256,
  localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_c = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder with programmable wait states.
// Build option: DMEM_BYTE_EN adds req_be and byte-masked stores.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef DMEM_BYTE_EN
  input  logic [BE_W-1:0]   req_be,
`endif
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              req_ready_q, req_ready_d;

  logic [BE_W-1:0]   live_be_c;
  req_t              live_c, op_c;
  logic              op_err_c, mem_we_c;
  logic [DATA_W-1:0] mem_rdata_c;

`ifdef DMEM_BYTE_EN
  assign live_be_c = req_be;
`else
  assign live_be_c = '1;
`endif

  // In IDLE the live request drives the array so a zero-wait build can complete on the accept edge.
  assign live_c   = '{we: req_we, addr: req_addr, wdata: req_wdata, be: live_be_c};
  assign op_c     = (state_q == IDLE) ? live_c : req_q;
  assign op_err_c = addr_err(op_c.addr, DEPTH_WORDS);

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk_i  (clock),
    .we_i   (mem_we_c),
    .addr_i (op_c.addr[IDX_W+1:2]),
    .wdata_i(op_c.wdata),
    .be_i   (op_c.be),
    .rdata_c(mem_rdata_c)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_we_c     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d = live_c;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Store and load both resolve on the edge that enters RESP; reset suppresses the write.
    if ((state_d == RESP) && (state_q != RESP)) begin
      mem_we_c     = op_c.we && !op_err_c && reset;
      resp_err_d   = op_err_c;
      resp_rdata_d = (op_c.we || op_err_c) ? '0 : mem_rdata_c;
    end

    resp_valid_d = (state_d == RESP);
    req_ready_d  = (state_d == IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      req_ready_q  <= req_ready_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words of storage; SHALL be a power of two, 4..4096.
REQ-002 Parameter WAIT_CYCLES, default 2, wait-state cycles inserted between request acceptance and response; SHALL be 0..15.
REQ-003 Port clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-low reset.
REQ-005 Port req_valid  input  1  initiator presents a request.
REQ-006 Port req_ready  output  1  responder can accept a request.
REQ-007 Port req_we  input  1  1 = store, 0 = load.
REQ-008 Port req_addr  input  32  byte address.
REQ-009 Port req_wdata  input  32  store data.
REQ-010 Port req_be  input  4  byte enables; present only when DMEM_BYTE_EN is defined.
REQ-011 Port resp_valid  output  1  response available.
REQ-012 Port resp_ready  input  1  initiator accepts the response.
REQ-013 Port resp_rdata  output  32  load data.
REQ-014 Port resp_err  output  1  request was misaligned or out of range.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with req_valid=1 and req_ready=1, and req_we, req_addr, req_wdata and req_be SHALL be latched on that cycle.
REQ-017 On acceptance, the FSM SHALL move IDLE->WAIT and load the wait counter with WAIT_CYCLES-1; when WAIT_CYCLES=0 it SHALL move IDLE->RESP directly.
REQ-018 In WAIT the counter SHALL decrement each cycle; on the cycle it reads 0, the FSM SHALL move WAIT->RESP.
REQ-019 Latency SHALL be WAIT_CYCLES+1 cycles from the acceptance edge to the first cycle with resp_valid=1.
REQ-020 The store write and the load read SHALL both take effect on the edge that enters RESP.
REQ-021 resp_valid SHALL be 1 exactly while in RESP.
REQ-022 resp_rdata and resp_err SHALL stay stable while resp_valid=1 and resp_ready=0.
REQ-023 On resp_valid=1 and resp_ready=1, the FSM SHALL return to IDLE; back-to-back accepts are not possible (minimum one IDLE cycle between requests).
REQ-024 Error condition: req_addr[1:0]!=0 or req_addr[31:2]>=DEPTH_WORDS -> resp_err=1, resp_rdata=0, no storage modified.
REQ-025 For a successful load, resp_rdata SHALL be the word at index req_addr[31:2] and resp_err SHALL be 0.
REQ-026 For a store, resp_rdata SHALL be 0 and resp_err SHALL be 0 unless the error condition holds.
REQ-027 Inputs on req_* while not in IDLE SHALL be ignored.

Reset
REQ-028 On a clock edge with reset=0: state=IDLE, wait counter=0, resp_valid=0, resp_rdata=0, resp_err=0; after reset, req_ready SHALL be 1 in the first cycle with reset=1.
REQ-029 Storage contents SHALL NOT be cleared by reset.
REQ-030 Reset asserted in WAIT SHALL discard the pending store (no write); reset in RESP SHALL drop the response.

Configuration
REQ-031 Macro DMEM_BYTE_EN defined: req_be exists, and a store writes only the bytes whose req_be bit is 1; req_be=0000 SHALL be a legal no-op store with resp_err=0.
REQ-032 Macro DMEM_BYTE_EN undefined: req_be is absent and every store writes all 4 bytes.

Structure
REQ-033 Package dmem_pkg SHALL hold the FSM state enum, ADDR_W=32, DATA_W=32 and the BE_W=4 constant.
REQ-034 Storage SHALL be one sub-module, dmem_array: single-port synchronous write, with byte-lane write enables under DMEM_BYTE_EN.

Verification
REQ-035 Reset then store 0xDEADBEEF @0x10, then load @0x10 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid first seen 3 cycles after each accept (WAIT_CYCLES=2).
REQ-036 Load @0x13 and load @(DEPTH_WORDS*4) -> resp_err=1, resp_rdata=0; a following load of the original address shows storage unchanged.
REQ-037 Hold resp_ready=0 for 5 cycles -> resp_valid, resp_rdata and resp_err constant and req_ready=0 throughout; then resp_ready=1 -> IDLE next cycle.
REQ-038 WAIT_CYCLES=0 build: load accepted at cycle N -> resp_valid=1 at cycle N+1.
REQ-039 DMEM_BYTE_EN: word=0x11223344, store 0xAABBCCDD with be=0101 -> load returns 0x11BB33DD.
REQ-040 Assert reset=0 one cycle after a store is accepted -> subsequent load of that address returns the pre-store value.
